// File: rtl/wf_rx_frame_filter_if.sv
// Byte-stream bundle between the Manchester receiver, the frame filter and the UART
// transmit side: decoded receive bytes in, committed payload bytes out.
interface wf_rx_frame_filter_if;
    logic       cardet;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output cardet, rx_data, rx_valid, rx_error, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  cardet, rx_data, rx_valid, rx_error, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/wf_rx_frame_filter.sv
// WimpFi receive frame filter: address/type parsing, CRC-8 check and a commit/rollback
// payload FIFO so only fully accepted frames reach the UART side.
module wf_rx_frame_filter #(
    parameter logic [7:0] MAC_ADDR       = 8'h42,
    parameter logic [7:0] BROADCAST_ADDR = 8'h2A,
    parameter int          DEPTH          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    wf_rx_frame_filter_if.slave   bus,
    output logic                  frame_ok,
    output logic                  crc_err,
    output logic [7:0]            rx_src,
    output logic [7:0]            rerrcnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [2:0] {IDLE, DEST, SRC, TYPE, PAYLOAD, SKIP, END} state_t;

    state_t          state_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   commit_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   rd_ptr_next;
    logic [7:0]      crc_reg;
    logic [7:0]      crc_prev_reg;
    logic [7:0]      src_reg;
    logic [7:0]      last_byte_reg;
    logic [7:0]      rx_src_reg;
    logic [7:0]      rerrcnt_reg;
    logic [7:0]      out_data_reg;
    logic            crc_mode_reg;
    logic            reached_payload_reg;
    logic            frame_ok_reg;
    logic            crc_err_reg;

    logic [7:0]      mem [DEPTH];

    logic            pop;
    logic            full;
    logic            wr_en;
    logic [7:0]      crc_next;
    state_t          adv_state;

    // Bit-serial CRC-8 (poly 0x07) unrolled over one byte, LSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = {c[6:0], 1'b0} ^ ((c[7] ^ data[i]) ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign bus.out_valid = (rd_ptr_reg != commit_ptr_reg);
    assign bus.out_data  = out_data_reg;
    assign frame_ok      = frame_ok_reg;
    assign crc_err       = crc_err_reg;
    assign rx_src        = rx_src_reg;
    assign rerrcnt       = rerrcnt_reg;

    assign pop         = bus.out_valid && bus.out_ready;
    assign rd_ptr_next = pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
    assign full        = (wr_ptr_reg - rd_ptr_reg) == PW'(DEPTH);
    assign wr_en       = (state_reg == PAYLOAD) && bus.rx_valid && !bus.rx_error && !full;
    assign crc_next    = crc8_byte(crc_reg, bus.rx_data);

    // Where the parser would go after consuming the current byte (SKIP on reject/overflow).
    always_comb begin
        adv_state = state_reg;
        if (bus.rx_valid) begin
            case (state_reg)
                DEST:    adv_state = (bus.rx_data == MAC_ADDR || bus.rx_data == BROADCAST_ADDR) ? SRC : SKIP;
                SRC:     adv_state = TYPE;
                TYPE:    adv_state = (bus.rx_data == 8'h30 || bus.rx_data == 8'h31) ? PAYLOAD : SKIP;
                PAYLOAD: adv_state = full ? SKIP : PAYLOAD;
                default: adv_state = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg           <= IDLE;
            wr_ptr_reg          <= '0;
            commit_ptr_reg      <= '0;
            rd_ptr_reg          <= '0;
            crc_reg             <= 8'h00;
            crc_prev_reg        <= 8'h00;
            src_reg             <= 8'h00;
            last_byte_reg       <= 8'h00;
            rx_src_reg          <= 8'h00;
            rerrcnt_reg         <= 8'h00;
            crc_mode_reg        <= 1'b0;
            reached_payload_reg <= 1'b0;
            frame_ok_reg        <= 1'b0;
            crc_err_reg         <= 1'b0;
        end else begin
            frame_ok_reg <= 1'b0;
            crc_err_reg  <= 1'b0;
            rd_ptr_reg   <= rd_ptr_next;
            case (state_reg)
                IDLE: begin
                    wr_ptr_reg <= commit_ptr_reg;
                    if (bus.cardet) begin
                        state_reg           <= DEST;
                        crc_reg             <= 8'h00;
                        crc_prev_reg        <= 8'h00;
                        crc_mode_reg        <= 1'b0;
                        reached_payload_reg <= 1'b0;
                    end
                end
                DEST, SRC, TYPE, PAYLOAD: begin
                    if (bus.rx_error) begin
                        wr_ptr_reg  <= commit_ptr_reg;
                        rerrcnt_reg <= sat_inc(rerrcnt_reg);
                        state_reg   <= SKIP;
                    end else begin
                        if (bus.rx_valid) begin
                            crc_prev_reg <= crc_reg;
                            crc_reg      <= crc_next;
                        end
                        if (bus.rx_valid && state_reg == SRC)
                            src_reg <= bus.rx_data;
                        if (bus.rx_valid && state_reg == TYPE)
                            crc_mode_reg <= bus.rx_data[0];
                        if (wr_en) begin
                            wr_ptr_reg    <= wr_ptr_reg + PW'(1);
                            last_byte_reg <= bus.rx_data;
                        end
                        if (adv_state == SKIP) begin
                            wr_ptr_reg <= commit_ptr_reg;
                            state_reg  <= SKIP;
                        end else if (!bus.cardet) begin
                            reached_payload_reg <= (adv_state == PAYLOAD);
                            state_reg           <= END;
                        end else begin
                            state_reg <= adv_state;
                        end
                    end
                end
                SKIP: begin
                    if (!bus.cardet)
                        state_reg <= IDLE;
                end
                END: begin
                    state_reg <= IDLE;
                    if (!reached_payload_reg) begin
                        wr_ptr_reg <= commit_ptr_reg;
                    end else if (!crc_mode_reg) begin
                        commit_ptr_reg <= wr_ptr_reg;
                        frame_ok_reg   <= 1'b1;
                        rx_src_reg     <= src_reg;
                    end else if (wr_ptr_reg != commit_ptr_reg && last_byte_reg == crc_prev_reg) begin
                        // The trailing CRC byte stays behind the commit point and is overwritten later.
                        commit_ptr_reg <= wr_ptr_reg - PW'(1);
                        frame_ok_reg   <= 1'b1;
                        rx_src_reg     <= src_reg;
                    end else begin
                        wr_ptr_reg  <= commit_ptr_reg;
                        crc_err_reg <= 1'b1;
                        rerrcnt_reg <= sat_inc(rerrcnt_reg);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg[AW-1:0]] <= bus.rx_data;
    end

    // Head byte is re-read every cycle, so a freshly written slot is current before it commits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            out_data_reg <= 8'h00;
        else
            out_data_reg <= mem[rd_ptr_next[AW-1:0]];
    end
endmodule

// File: tb/tb_wf_rx_frame_filter.sv
// Scoreboard bench for wf_rx_frame_filter: frames are judged by a frame-level model when
// issued; a monitor matches delivered bytes and frame_ok/crc_err pulses against the queues.
module tb_wf_rx_frame_filter;
    localparam logic [7:0] MAC   = 8'h42;
    localparam logic [7:0] BC    = 8'h2A;
    localparam int         DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_ok, crc_err;
    logic [7:0] rx_src, rerrcnt;

    wf_rx_frame_filter_if bus();

    wf_rx_frame_filter #(.MAC_ADDR(MAC), .BROADCAST_ADDR(BC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .frame_ok(frame_ok), .crc_err(crc_err), .rx_src(rx_src), .rerrcnt(rerrcnt)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];     // expected delivered bytes
    logic [8:0] ev_q[$];      // expected pulses: bit8=1 frame_ok (src in [7:0]), 0 crc_err
    logic [7:0] frame_q[$];   // frame under construction
    int         m_err = 0;
    bit         rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] crc_of(input int n);
        logic [7:0] c = 8'h00;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 8; i++) begin
                logic fb;
                fb = c[7] ^ frame_q[k][i];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    // Monitor: one line per delivered byte / pulse.
    always @(negedge clk) begin
        logic [7:0] e;
        logic [8:0] ev;
        if (rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_data: got %0h expected no byte", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    $display("byte out %02h (expected %02h)", bus.out_data, e);
                    check("out_data", {24'd0, bus.out_data}, {24'd0, e});
                end
            end
            if (frame_ok && crc_err) begin
                checks++; errors++;
                $display("FAIL pulse_overlap: got frame_ok=1 crc_err=1 required at most one");
            end else if (frame_ok || crc_err) begin
                if (ev_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pulse: got frame_ok=%0d crc_err=%0d expected no pulse", frame_ok, crc_err);
                end else begin
                    ev = ev_q.pop_front();
                    $display("pulse frame_ok=%0d crc_err=%0d rx_src=%02h", frame_ok, crc_err, rx_src);
                    check("pulse_kind", {31'd0, frame_ok}, {31'd0, ev[8]});
                    if (frame_ok) check("rx_src", {24'd0, rx_src}, {24'd0, ev[7:0]});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Judge frame_q with the frame rules, queue expectations, then drive it.
    task automatic send_frame(input int err_at, input bit last_low);
        int  n     = frame_q.size();
        int  plen  = n - 3;
        bit  addr_ok = (frame_q[0] == MAC) || (frame_q[0] == BC);
        bit  typ_ok  = (frame_q[2] == 8'h30) || (frame_q[2] == 8'h31);
        if (err_at >= 0) begin
            if (addr_ok && typ_ok && m_err < 255) m_err++;
        end else if (addr_ok && typ_ok && exp_q.size() + plen <= DEPTH) begin
            if (frame_q[2] == 8'h30) begin
                for (int k = 3; k < n; k++) exp_q.push_back(frame_q[k]);
                ev_q.push_back({1'b1, frame_q[1]});
            end else if (plen >= 1 && frame_q[n-1] == crc_of(n - 1)) begin
                for (int k = 3; k < n - 1; k++) exp_q.push_back(frame_q[k]);
                ev_q.push_back({1'b1, frame_q[1]});
            end else begin
                ev_q.push_back(9'd0);
                if (m_err < 255) m_err++;
            end
        end
        bus.cardet = 1'b1;
        tick();
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            if (k == err_at) begin
                bus.rx_error = 1'b1; tick(); bus.rx_error = 1'b0;
            end
            bus.rx_data  = frame_q[k];
            bus.rx_valid = 1'b1;
            if (last_low && k == n - 1) bus.cardet = 1'b0;
            tick();
            bus.rx_valid = 1'b0;
        end
        if (err_at >= n) begin
            bus.rx_error = 1'b1; tick(); bus.rx_error = 1'b0;
        end
        bus.cardet = 1'b0;
        repeat (3) tick();
        check("rerrcnt", {24'd0, rerrcnt}, m_err);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || ev_q.size() != 0) && t < 500) begin
            tick();
            t++;
        end
        checks++;
        if (exp_q.size() != 0 || ev_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d bytes and %0d pulses still pending, required 0", exp_q.size(), ev_q.size());
            exp_q.delete();
            ev_q.delete();
        end
    endtask

    task automatic build(input logic [7:0] d, input logic [7:0] s, input logic [7:0] t, input int plen);
        frame_q.delete();
        frame_q.push_back(d);
        frame_q.push_back(s);
        frame_q.push_back(t);
        for (int k = 0; k < plen; k++) frame_q.push_back(8'($urandom));
    endtask

    task automatic gen_random();
        int         kind = $urandom_range(0, 5);
        int         plen = $urandom_range(0, 12);
        int         err_at = -1;
        bit         last_low;
        logic [7:0] d = ($urandom_range(0, 1) != 0) ? MAC : BC;
        logic [7:0] t = (kind == 1 || kind == 2) ? 8'h31 : 8'h30;
        logic [7:0] c;
        if (kind == 3) begin
            do d = 8'($urandom); while (d == MAC || d == BC);
        end
        if (kind == 4) begin
            do t = 8'($urandom); while (t == 8'h30 || t == 8'h31);
        end
        if (kind == 5 && ($urandom_range(0, 1) != 0)) t = 8'h31;
        build(d, 8'($urandom), t, plen);
        if (kind == 1 || kind == 2) begin
            c = crc_of(frame_q.size());
            frame_q.push_back((kind == 2) ? ~c : c);
        end
        if (kind == 5) err_at = $urandom_range(3, frame_q.size());
        last_low = (kind != 5) && (frame_q.size() >= 4) && ($urandom_range(0, 1) != 0);
        send_frame(err_at, last_low);
    endtask

    initial begin
        logic [7:0] part [4];
        logic [7:0] c;
        part = '{8'h42, 8'h44, 8'h30, 8'h55};
        bus.cardet = 1'b0; bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0; bus.out_ready = 1'b1;

        #12;
        check("reset_out_valid", {31'd0, bus.out_valid}, 0);
        check("reset_frame_ok", {31'd0, frame_ok}, 0);
        check("reset_crc_err", {31'd0, crc_err}, 0);
        check("reset_rx_src", {24'd0, rx_src}, 0);
        check("reset_rerrcnt", {24'd0, rerrcnt}, 0);
        tick();
        rst = 1'b1;
        tick();

        // Type '0' frame.
        frame_q = '{8'h42, 8'h44, 8'h30, 8'h11, 8'h22, 8'h33};
        send_frame(-1, 1'b0);
        drain();
        check("t0_rx_src", {24'd0, rx_src}, 32'h44);

        // Type '1' frame, good CRC, then bad CRC, then good again.
        frame_q = '{8'h2A, 8'h44, 8'h31, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        c = crc_of(7);
        frame_q.push_back(c);
        send_frame(-1, 1'b0);
        drain();
        frame_q[7] = ~c;
        send_frame(-1, 1'b0);
        drain();
        frame_q[7] = c;
        send_frame(-1, 1'b1);
        drain();

        // Misaddressed and bad-type frames.
        frame_q = '{8'h55, 8'h44, 8'h30, 8'h01, 8'h02};
        send_frame(-1, 1'b0);
        for (int ty = 8'h32; ty <= 8'h42; ty += 8) begin
            build(MAC, 8'h44, 8'(ty), 3);
            send_frame(-1, 1'b0);
        end
        build(MAC, 8'h47, 8'h30, 5);
        send_frame(5, 1'b0);
        drain();

        // Randomised traffic with random backpressure.
        rand_ready = 1'b1;
        for (int f = 0; f < 80; f++) begin
            gen_random();
            drain();
        end

        // Error saturation.
        for (int f = 0; f < 300; f++) begin
            build(BC, 8'h10, 8'h30, 3);
            send_frame(4, 1'b0);
        end
        check("rerrcnt_sat", {24'd0, rerrcnt}, 32'hFF);
        drain();

        // Overflow with a stalled consumer.
        rand_ready = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        build(MAC, 8'h21, 8'h30, 10);
        send_frame(-1, 1'b0);
        build(MAC, 8'h22, 8'h30, 10);
        send_frame(-1, 1'b0);
        check("ovf_out_valid", {31'd0, bus.out_valid}, 1);
        bus.out_ready = 1'b1;
        drain();
        tick();
        check("ovf_empty", {31'd0, bus.out_valid}, 0);

        // Asynchronous reset mid-frame with committed, unread bytes.
        bus.out_ready = 1'b0;
        build(BC, 8'h33, 8'h30, 3);
        send_frame(-1, 1'b0);
        bus.cardet = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.rx_data = part[k]; bus.rx_valid = 1'b1; tick(); bus.rx_valid = 1'b0;
        end
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, bus.out_valid}, 0);
        check("arst_out_data", {24'd0, bus.out_data}, 0);
        check("arst_frame_ok", {31'd0, frame_ok}, 0);
        check("arst_crc_err", {31'd0, crc_err}, 0);
        check("arst_rx_src", {24'd0, rx_src}, 0);
        check("arst_rerrcnt", {24'd0, rerrcnt}, 0);
        exp_q.delete();
        ev_q.delete();
        m_err = 0;
        bus.cardet = 1'b0;
        tick();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        build(MAC, 8'h5A, 8'h30, 4);
        send_frame(-1, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not reach its end, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
